io_input_port: RTL and testbench
================================

# io_input_port

Input conditioning stage directly upstream of the pipelined CPU's MEM-stage I/O: it turns raw board switches and push-buttons into the two 32-bit read-only words the CPU sees as `in_port0` and `in_port1`. Raw pins are synchronised, debounced on a shared sample tick, and registered so that software polling via `lw` sees glitch-free values. A press counter lets programs detect new key presses by polling, with no interrupt support.

## Interface
- `SW_WIDTH`, 10, number of slide switches (1..32)
- `KEY_WIDTH`, 4, number of push-buttons (1..16)
- `DB_TICK`, 50000, clock cycles per debounce sample tick (>=2)
- `DB_SAMPLES`, 4, consecutive differing samples required to accept a change (>=1)

- `clock`  in  1  system clock (same clock as the CPU pipeline registers)
- `resetn`  in  1  synchronous, active-low reset
- `sw`  in  SW_WIDTH  raw switches, asynchronous, 1 = on
- `key`  in  KEY_WIDTH  raw buttons, asynchronous, active-low (0 = pressed)
- `in_port0`  out  32  {zero-extend, debounced sw}
- `in_port1`  out  32  {press_count[15:0], zero pad, debounced pressed[KEY_WIDTH-1:0]}
- `key_event`  out  KEY_WIDTH  one-cycle pulse per key on a debounced press

## Operation
- Synchroniser: two flops on every `sw` and `key` bit. Key bits are inverted after synchronisation, giving `pressed` with 1 = pressed.
- Prescaler: counts 0..DB_TICK-1 and wraps. `tick` is high for the single cycle in which the count equals DB_TICK-1.
- Per-bit debouncer (SW_WIDTH+KEY_WIDTH instances):
  - Each instance holds a `stable` bit and a sample counter of width clog2(DB_SAMPLES+1).
  - On `tick`, if the synchronised value equals `stable`, the counter clears to 0.
  - On `tick`, if it differs, the counter increments. When the counter reaches DB_SAMPLES, `stable` takes the new value and the counter clears in the same edge.
  - With no `tick`, nothing changes.
- `in_port0[SW_WIDTH-1:0]` = stable switch bits; all higher bits are 0.
- `in_port1[KEY_WIDTH-1:0]` = stable pressed bits; bits [15:KEY_WIDTH] are 0; bits [31:16] = press_count.
- Rising edge of any stable pressed bit:
  - `key_event[i]` = 1 for exactly one cycle.
  - press_count increments by 1 per tick in which at least one key rises, even if several keys rise on the same tick.
- Releases produce no event and no count.
- press_count wraps from 0xFFFF to 0x0000.

## Timing
- Reset state:
  - synchroniser flops are sw = 0 and key = 1 (idle);
  - prescaler, sample counters, stable bits, press_count and `key_event` are all 0;
  - therefore `in_port0` = 0 and `in_port1` = 0.
- The reset edge overrides every other update on the same edge. A reset asserted mid-debounce discards partial sample counts.
- Latency from raw pin change to a stable bit change:
  - 2 cycles for synchronisation, plus
  - wait to the next tick, plus
  - DB_SAMPLES ticks in total.
- Bounds: minimum 2 + (DB_SAMPLES-1)·DB_TICK + 1 cycles, maximum 2 + DB_SAMPLES·DB_TICK cycles.
- `in_port0` and `in_port1` change on the same edge as `stable`; `in_port1[31:16]` changes on that same edge.
- `key_event` is asserted in the cycle following the edge where the stable bit rose, and lasts one cycle.
- A bounce that reverses before DB_SAMPLES consecutive ticks resets that bit's counter, and no change is accepted.
- Outputs are registered only. There is no combinational path from `sw` or `key` to any output.

## Configuration
- `IO_PRESS_COUNT_EN`:
  - Defined: press_count is implemented and drives `in_port1[31:16]`.
  - Undefined: no counter is synthesised and `in_port1[31:16]` is tied to 0.
- `key_event` and debouncing are identical in both builds.

## Test plan
All scenarios use DB_TICK=4, DB_SAMPLES=3, SW_WIDTH=10, KEY_WIDTH=4, with the macro defined unless stated.
- Reset: hold `resetn`=0 for 3 cycles with sw=0x3FF and key=0 → `in_port0`=0, `in_port1`=0, `key_event`=0 throughout reset.
- Switch load: set sw=0x2A5 and hold → `in_port0`=0x000002A5 no earlier than cycle 11 and no later than cycle 14 after the change; its value before then is 0.
- Bounce reject: sw[0]=1 for 2 ticks then back to 0 → `in_port0` stays 0 for the next 10 ticks.
- Key press:
  - key=4'b1101 held → `in_port1`=0x00010002 and `key_event`=4'b0010 for exactly 1 cycle.
  - Release, then press again → `in_port1` reads 0x00020002 while held.
- Simultaneous keys: key=4'b1010 applied on one cycle → `key_event`=4'b0101 for 1 cycle and press_count +1 only; the same stimulus with the macro undefined → `in_port1`=0x00000005.
- Reset mid-debounce: after 2 differing ticks on sw[3], pulse `resetn` low → a full 3 further ticks are required before `in_port0`=0x00000008.

Source files
------------

// File: rtl/io_input_port_if.sv
// io_input_port_if: board-pin and CPU-facing signal bundle of io_input_port.
// The slave modport is the conditioning block itself; master is the board/CPU side.
interface io_input_port_if #(
    parameter int SW_WIDTH  = 10,
    parameter int KEY_WIDTH = 4
);
    logic [SW_WIDTH-1:0]  sw;         // raw switches, 1 = on
    logic [KEY_WIDTH-1:0] key;        // raw buttons, 0 = pressed
    logic [31:0]          in_port0;   // debounced switches, zero-extended
    logic [31:0]          in_port1;   // {press_count, zero pad, debounced pressed}
    logic [KEY_WIDTH-1:0] key_event;  // one-cycle pulse per debounced press

    modport master (
        output sw, key,
        input  in_port0, in_port1, key_event
    );

    modport slave (
        input  sw, key,
        output in_port0, in_port1, key_event
    );
endinterface

// File: rtl/io_input_port.sv
// io_input_port: synchronises, debounces and registers board switches and
// push-buttons into the two read-only words polled by the CPU.
// Optional feature macro: IO_PRESS_COUNT_EN enables the 16-bit press counter
// in in_port1[31:16]; without it those bits are tied to zero.
module io_input_port #(
    parameter int SW_WIDTH   = 10,
    parameter int KEY_WIDTH  = 4,
    parameter int DB_TICK    = 50000,
    parameter int DB_SAMPLES = 4
) (
    input logic             clock,
    input logic             resetn,
    io_input_port_if.slave  bus
);
    localparam int NB = SW_WIDTH + KEY_WIDTH;     // debounced bits: {pressed, sw}
    localparam int CW = $clog2(DB_SAMPLES + 1);   // sample counter width
    localparam int PW = $clog2(DB_TICK);          // prescaler width

    // Two-flop synchronisers
    logic [SW_WIDTH-1:0]  sw_meta_q,  sw_sync_q;
    logic [KEY_WIDTH-1:0] key_meta_q, key_sync_q;

    // Prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // Debouncers
    logic [NB-1:0]         sample;
    logic [NB-1:0]         stable_q, stable_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;

    // Press detection
    logic [KEY_WIDTH-1:0] rise;
    logic [KEY_WIDTH-1:0] key_event_q;
    logic [15:0]          press_hi;

    // Synchronise raw pins; buttons idle high so their flops reset to 1
    always_ff @(posedge clock) begin
        // NOTE: every clocked assignment is non-blocking so all flops see the
        // pre-edge values of each other, exactly like the hardware does.
        if (!resetn) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            sw_meta_q  <= bus.sw;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= bus.key;
            key_sync_q <= key_meta_q;
        end
    end

    assign tick   = (presc_q == PW'(DB_TICK - 1));
    assign sample = {~key_sync_q, sw_sync_q};

    // Prescaler next state: count 0..DB_TICK-1 and wrap
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    // Debouncer next state: accept a new level after DB_SAMPLES differing ticks
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal
        // unassigned, which would otherwise infer a latch.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            for (int b = 0; b < NB; b++) begin
                if (sample[b] == stable_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CW'(DB_SAMPLES - 1)) begin
                    stable_d[b] = sample[b];
                    cnt_d[b]    = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end
    end

    // A debounced press is a rising stable pressed bit
    assign rise = stable_d[NB-1:SW_WIDTH] & ~stable_q[NB-1:SW_WIDTH];

    // Prescaler, debouncer state and press pulses
    always_ff @(posedge clock) begin
        if (!resetn) begin
            presc_q     <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            key_event_q <= '0;
        end else begin
            presc_q     <= presc_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            key_event_q <= rise;
        end
    end

`ifdef IO_PRESS_COUNT_EN
    logic [15:0] press_cnt_q, press_cnt_d;

    // One count per edge on which any key rises; wraps naturally at 16 bits
    always_comb begin
        press_cnt_d = press_cnt_q;
        if (|rise) begin
            press_cnt_d = press_cnt_q + 16'd1;
        end
    end

    // Press counter register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_hi = press_cnt_q;
`else
    assign press_hi = 16'h0000;
`endif

    assign bus.in_port0  = 32'(stable_q[SW_WIDTH-1:0]);
    assign bus.in_port1  = {press_hi, 16'(stable_q[NB-1:SW_WIDTH])};
    assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed scenarios plus randomized pin activity, all
// compared every cycle against a tick-history reference model.
module tb_io_input_port;
    localparam int SWW = 10;
    localparam int KW  = 4;
    localparam int T   = 4;
    localparam int S   = 3;
    localparam int NB  = SWW + KW;
    localparam int HN  = 4096;

`ifdef IO_PRESS_COUNT_EN
    localparam logic [31:0] EXP_SECOND_PRESS = 32'h0002_0002;
    localparam logic [31:0] EXP_SIMUL_PRESS  = 32'h0003_0005;
`else
    localparam logic [31:0] EXP_SECOND_PRESS = 32'h0000_0002;
    localparam logic [31:0] EXP_SIMUL_PRESS  = 32'h0000_0005;
`endif

    logic clock;
    logic resetn;

    io_input_port_if #(.SW_WIDTH(SWW), .KEY_WIDTH(KW)) bus ();

    io_input_port #(
        .SW_WIDTH  (SWW),
        .KEY_WIDTH (KW),
        .DB_TICK   (T),
        .DB_SAMPLES(S)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pins reach the sampler two edges late; every T-th edge
    // a sample is logged, and a bit flips once its last S logged samples since
    // the previous flip all disagree with the current level.
    logic [SWW-1:0] m_s1, m_s2;
    logic [KW-1:0]  m_k1, m_k2;
    int             m_phase;
    logic [NB-1:0]  m_stable;
    logic [NB-1:0]  m_hist [HN];
    int             m_ntick;
    int             m_last [NB];
    logic [KW-1:0]  m_ev;
    logic [15:0]    m_cnt;

    task automatic model_edge(input logic [SWW-1:0] s_in, input logic [KW-1:0] k_in, input logic rn);
        logic [NB-1:0] samp;
        logic [NB-1:0] old;
        bit            all_diff;
        if (!rn) begin
            m_s1 = '0; m_s2 = '0; m_k1 = '1; m_k2 = '1;
            m_phase = 0; m_stable = '0; m_ntick = 0;
            m_ev = '0; m_cnt = '0;
            for (int b = 0; b < NB; b++) m_last[b] = 0;
            return;
        end
        samp = {~m_k2, m_s2};
        old  = m_stable;
        m_ev = '0;
        if (m_phase == T - 1) begin
            m_hist[m_ntick % HN] = samp;
            m_ntick++;
            for (int b = 0; b < NB; b++) begin
                if (m_ntick - m_last[b] >= S) begin
                    all_diff = 1'b1;
                    for (int j = 1; j <= S; j++)
                        if (m_hist[(m_ntick - j) % HN][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[b] = samp[b];
                        m_last[b]   = m_ntick;
                    end
                end
            end
            m_ev = m_stable[NB-1:SWW] & ~old[NB-1:SWW];
`ifdef IO_PRESS_COUNT_EN
            if (m_ev != '0) m_cnt = m_cnt + 16'd1;
`endif
        end
        m_phase = (m_phase + 1) % T;
        m_s2 = m_s1; m_s1 = s_in;
        m_k2 = m_k1; m_k1 = k_in;
    endtask

    // One clock: advance the model with the pins present at the edge, then
    // compare all outputs 1 ns after the edge.
    task automatic cyc();
        logic [SWW-1:0] s;
        logic [KW-1:0]  k;
        logic           r;
        s = bus.sw; k = bus.key; r = resetn;
        @(posedge clock);
        model_edge(s, k, r);
        #1;
        check("in_port0", bus.in_port0, {22'h0, m_stable[SWW-1:0]});
        check("in_port1", bus.in_port1, {m_cnt, 12'h0, m_stable[NB-1:SWW]});
        check("key_event", 32'(bus.key_event), 32'(m_ev));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ev_cnt;
        logic [SWW-1:0] nsw;

        // Reset with every pin active: outputs must stay at zero
        resetn = 1'b0; bus.sw = 10'h3FF; bus.key = 4'h0;
        repeat (3) begin
            cyc();
            check("rst_p0", bus.in_port0, 32'h0);
            check("rst_p1", bus.in_port1, 32'h0);
            check("rst_ev", 32'(bus.key_event), 32'h0);
        end
        bus.sw = '0; bus.key = 4'hF;
        cyc();
        resetn = 1'b1;
        repeat (5) cyc();

        // Switch load latency window
        bus.sw = 10'h2A5;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (bus.in_port0 == 32'h2A5) begin lat = n; break; end
        end
        check("sw_latency_in_window", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("sw_load_value", bus.in_port0, 32'h0000_02A5);

        // Return switches to zero, then bounce sw[0] for two ticks
        bus.sw = '0;
        repeat (20) cyc();
        bus.sw = 10'h001;
        repeat (2 * T) cyc();
        bus.sw = '0;
        repeat (10 * T) begin
            cyc();
            check("bounce_hold", bus.in_port0, 32'h0);
        end

        // First press of key[1]
        bus.key = 4'b1101;
        ev_cnt = 0;
        repeat (20) begin
            cyc();
            if (bus.key_event == 4'b0010) ev_cnt++;
        end
        check("press1_event_once", 32'(ev_cnt), 32'd1);
        check("press1_port1", bus.in_port1[15:0], 32'h0002);

        // Release, press again
        bus.key = 4'hF;
        repeat (20) cyc();
        check("release_no_event", 32'(bus.key_event), 32'h0);
        bus.key = 4'b1101;
        repeat (20) cyc();
        check("press2_port1", bus.in_port1, EXP_SECOND_PRESS);

        // Two keys on one cycle: one event pulse, one count
        bus.key = 4'hF;
        repeat (20) cyc();
        bus.key = 4'b1010;
        ev_cnt = 0;
        repeat (20) begin
            cyc();
            if (bus.key_event == 4'b0101) ev_cnt++;
        end
        check("simul_event_once", 32'(ev_cnt), 32'd1);
        check("simul_port1", bus.in_port1, EXP_SIMUL_PRESS);
        bus.key = 4'hF;
        repeat (20) cyc();

        // Reset mid-debounce discards partial sample counts
        bus.sw = 10'h008;
        repeat (10) begin
            cyc();
            check("middb_pending", bus.in_port0, 32'h0);
        end
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (bus.in_port0 == 32'h8) begin lat = n; break; end
        end
        check("middb_full_latency", 32'(lat), 32'd12);

        // Randomized pin activity with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            nsw = bus.sw;
            if ($urandom_range(0, 1) == 0) nsw = 10'($urandom);
            else nsw[$urandom_range(0, SWW - 1)] = ~nsw[$urandom_range(0, SWW - 1)];
            bus.sw  = nsw;
            bus.key = 4'($urandom);
            resetn  = ($urandom_range(0, 60) != 0);
            repeat ($urandom_range(1, 24)) begin
                cyc();
                resetn = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
